output_compare: RTL and testbench

Output-compare pulse generator: the transmit-side counterpart of the input capture counter. It drives a registered output pin with a programmed burst of pulses (high time, low time, pulse count) and counts the pulses it has emitted. It exposes a per-pulse flag and a count value with the same meaning as the capture side, so a capture channel looped back to this pin reads the same count. It sits beside the input capture blocks in the 16-bit counter peripheral.

---
 rtl/output_compare_if.sv | 36 +++
 rtl/output_compare.sv | 128 ++++++++++++
 tb/tb_output_compare.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/output_compare_if.sv
// Output-compare control/status bundle: burst programming in, pin and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; start/stop are level-sampled commands, all status is registered.
//
// Ports (as seen by the compare block through the slave modport):
//   i_start, i_stop, i_cnt_en      burst commands and count enable
//   i_num, i_high, i_low           pulses per burst, high/low phase lengths
//   o_cmp_pin, o_oc_flg            compare pin and per-pulse flag
//   o_busy, o_done, o_cnt_data     burst status and emitted-pulse count
interface output_compare_if #(
    parameter int CNT_W = 16
);
    logic             i_start;
    logic             i_stop;
    logic             i_cnt_en;
    logic [CNT_W-1:0] i_num;
    logic [CNT_W-1:0] i_high;
    logic [CNT_W-1:0] i_low;
    logic             o_cmp_pin;
    logic             o_oc_flg;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_cnt_data;

    // Controller side (register file / testbench).
    modport master (
        output i_start, i_stop, i_cnt_en, i_num, i_high, i_low,
        input  o_cmp_pin, o_oc_flg, o_busy, o_done, o_cnt_data
    );

    // Pulse generator side.
    modport slave (
        input  i_start, i_stop, i_cnt_en, i_num, i_high, i_low,
        output o_cmp_pin, o_oc_flg, o_busy, o_done, o_cnt_data
    );
endinterface

// File: rtl/output_compare.sv
// Output-compare burst generator: drives a registered pin with num pulses of high/low length.
// Latency: pin rises the cycle after start is sampled; every output is a flop (no comb path).
// Backpressure: none; i_cnt_en=0 freezes the timer/state/pin, i_stop aborts to IDLE next cycle.
//
// Ports:
//   i_sysclk    system clock, rising edge
//   i_sysrst_n  asynchronous active-low reset
//   oc          output_compare_if.slave: commands and programming in, pin/flag/status out
//               (the interface CNT_W must match this module's CNT_W)
module output_compare #(
    parameter int CNT_W = 16
) (
    input  logic           i_sysclk,
    input  logic           i_sysrst_n,
    output_compare_if.slave oc
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] num_sh;
    logic [CNT_W-1:0] high_sh;
    logic [CNT_W-1:0] low_sh;
    logic [CNT_W-1:0] cnt;
    logic             pin;
    logic             flg;
    logic             done;

    // Timer load value for a phase: a zero length behaves like a length of one.
    function automatic logic [CNT_W-1:0] phase_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : (len - ONE);
    endfunction

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            num_sh  <= '0;
            high_sh <= '0;
            low_sh  <= '0;
            cnt     <= '0;
            pin     <= 1'b0;
            flg     <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Flag and done are single-cycle strobes.
            flg  <= 1'b0;
            done <= 1'b0;

            if (oc.i_stop) begin
                // Abort wins over everything, including a start in IDLE.
                // The pulse count is left intact so software can read how far it got.
                state <= ST_IDLE;
                pin   <= 1'b0;
                timer <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (oc.i_start) begin
                            num_sh  <= oc.i_num;
                            high_sh <= oc.i_high;
                            low_sh  <= oc.i_low;
                            // Clear-then-increment for the first pulse collapses to 1.
                            cnt     <= ONE;
                            flg     <= 1'b1;
                            pin     <= 1'b1;
                            timer   <= phase_m1(oc.i_high);
                            state   <= ST_HIGH;
                        end
                    end

                    ST_HIGH: begin
                        if (oc.i_cnt_en) begin
                            if (timer == '0) begin
                                pin   <= 1'b0;
                                timer <= phase_m1(low_sh);
                                state <= ST_LOW;
                            end else begin
                                timer <= timer - ONE;
                            end
                        end
                    end

                    ST_LOW: begin
                        if (oc.i_cnt_en) begin
                            if (timer == '0) begin
                                if ((num_sh != '0) && (cnt == num_sh)) begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end else begin
                                    // Flag and increment happen on the transition, so a
                                    // HIGH phase frozen by i_cnt_en is only counted once.
                                    // Free-run (num=0) lets the counter wrap naturally.
                                    cnt   <= cnt + ONE;
                                    flg   <= 1'b1;
                                    pin   <= 1'b1;
                                    timer <= phase_m1(high_sh);
                                    state <= ST_HIGH;
                                end
                            end else begin
                                timer <= timer - ONE;
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        pin   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oc.o_cmp_pin  = pin;
    assign oc.o_oc_flg   = flg;
    assign oc.o_busy     = (state != ST_IDLE);
    assign oc.o_done     = done;
    assign oc.o_cnt_data = cnt;

endmodule

// File: tb/tb_output_compare.sv
// Bench for output_compare: expected per-cycle output traces are queued at stimulus time
// and popped/compared on the falling edge of the cycle they belong to.
// A second 8-bit instance exercises free-run counter wrap in a short run.
module tb_output_compare;

    localparam int W  = 16;
    localparam int W2 = 8;

    logic i_sysclk   = 1'b0;
    logic i_sysrst_n = 1'b1;
    always #5 i_sysclk = ~i_sysclk;

    output_compare_if #(.CNT_W(W))  ocb ();
    output_compare_if #(.CNT_W(W2)) ocb2 ();

    output_compare #(.CNT_W(W)) dut (
        .i_sysclk   (i_sysclk),
        .i_sysrst_n (i_sysrst_n),
        .oc         (ocb)
    );

    output_compare #(.CNT_W(W2)) dut_w8 (
        .i_sysclk   (i_sysclk),
        .i_sysrst_n (i_sysrst_n),
        .oc         (ocb2)
    );

    // Expected output bundle: {pin, flg, busy, done, cnt[15:0]}
    typedef struct {
        int          cyc;
        int          id;
        logic [19:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge i_sysclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input logic pin, input logic flg, input logic busy,
                                         input logic done, input logic [15:0] cnt);
        return {pin, flg, busy, done, cnt};
    endfunction

    function automatic logic [19:0] observe(input int id);
        if (id == 0)
            return pack(ocb.o_cmp_pin, ocb.o_oc_flg, ocb.o_busy, ocb.o_done, ocb.o_cnt_data);
        return pack(ocb2.o_cmp_pin, ocb2.o_oc_flg, ocb2.o_busy, ocb2.o_done,
                    {8'h00, ocb2.o_cnt_data});
    endfunction

    // Scoreboard monitor: compare every queued expectation in its own cycle.
    always @(negedge i_sysclk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc < cyc)
                chk("late_entry", 32'(cyc), 32'(mon_e.cyc));
            else
                chk($sformatf("trace_dut%0d@%0d", mon_e.id, mon_e.cyc),
                    32'(observe(mon_e.id)), 32'(mon_e.val));
        end
    end

    // Expected trace of a burst from the timing rules: cycle k (1-based after the start
    // cycle c0) is pulse (k-1)/P+1, phase position (k-1)%P, pin high for the first H.
    task automatic push_burst(input int id, input int c0, input int h, input int l, input int kmax);
        int he;
        int le;
        int p;
        int mask;
        int ph;
        he   = (h == 0) ? 1 : h;
        le   = (l == 0) ? 1 : l;
        p    = he + le;
        mask = (id == 0) ? 32'hFFFF : 32'hFF;
        for (int k = 1; k <= kmax; k++) begin
            ph = (k - 1) % p;
            exp_q.push_back('{c0 + k, id,
                pack(ph < he, ph == 0, 1'b1, 1'b0, 16'(((k - 1) / p + 1) & mask))});
        end
    endtask

    task automatic push_idle(input int id, input int c, input logic done, input int cnt);
        exp_q.push_back('{c, id, pack(1'b0, 1'b0, 1'b0, done, 16'(cnt))});
    endtask

    task automatic tick();
        @(posedge i_sysclk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic start_burst(input int num, input int h, input int l);
        ocb.i_num   = 16'(num);
        ocb.i_high  = 16'(h);
        ocb.i_low   = 16'(l);
        ocb.i_start = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int c1;

        ocb.i_start  = 1'b0; ocb.i_stop  = 1'b0; ocb.i_cnt_en  = 1'b1;
        ocb.i_num    = '0;   ocb.i_high  = '0;   ocb.i_low     = '0;
        ocb2.i_start = 1'b0; ocb2.i_stop = 1'b0; ocb2.i_cnt_en = 1'b1;
        ocb2.i_num   = '0;   ocb2.i_high = '0;   ocb2.i_low    = '0;

        // Power-on reset.
        #1 i_sysrst_n = 1'b0;
        repeat (2) tick();
        chk("reset_dut0", 32'(observe(0)), 32'd0);
        chk("reset_dut1", 32'(observe(1)), 32'd0);
        i_sysrst_n = 1'b1;
        tick();

        // Basic burst num=3 H=2 L=3, with programming inputs and start toggled mid-burst.
        c0 = cyc;
        start_burst(3, 2, 3);
        push_burst(0, c0, 2, 3, 15);
        push_idle(0, c0 + 16, 1'b1, 3);
        push_idle(0, c0 + 17, 1'b0, 3);
        tick();
        ocb.i_start = 1'b0;
        repeat (3) tick();
        ocb.i_num = 16'd1; ocb.i_high = 16'd7; ocb.i_low = 16'd0; ocb.i_start = 1'b1;
        tick();
        ocb.i_start = 1'b0;
        drain();

        // Zero lengths: num=2 H=0 L=0 -> 1010, done in cycle 5.
        c0 = cyc;
        start_burst(2, 0, 0);
        push_burst(0, c0, 0, 0, 4);
        push_idle(0, c0 + 5, 1'b1, 2);
        tick();
        ocb.i_start = 1'b0;
        drain();

        // Back-to-back: second start accepted in the done cycle of the first burst.
        c0 = cyc;
        start_burst(1, 1, 2);
        push_burst(0, c0, 1, 2, 3);
        tick();
        ocb.i_start = 1'b0;
        repeat (3) tick();
        c1 = cyc;
        start_burst(2, 2, 1);
        exp_q.push_back('{c1, 0, pack(1'b0, 1'b0, 1'b0, 1'b1, 16'd1)});
        push_burst(0, c1, 2, 1, 6);
        push_idle(0, c1 + 7, 1'b1, 2);
        tick();
        ocb.i_start = 1'b0;
        drain();

        // Pause: num=1 H=4 L=4 with count enable low in cycles 2..4.
        c0 = cyc;
        start_burst(1, 4, 4);
        for (int k = 1; k <= 7; k++)
            exp_q.push_back('{c0 + k, 0, pack(1'b1, k == 1, 1'b1, 1'b0, 16'd1)});
        for (int k = 8; k <= 11; k++)
            exp_q.push_back('{c0 + k, 0, pack(1'b0, 1'b0, 1'b1, 1'b0, 16'd1)});
        push_idle(0, c0 + 12, 1'b1, 1);
        tick();
        ocb.i_start = 1'b0;
        tick();
        ocb.i_cnt_en = 1'b0;
        repeat (3) tick();
        ocb.i_cnt_en = 1'b1;
        drain();

        // Stop in cycle 7 of num=5 H=2 L=3: pin low from cycle 8, count 2, no done.
        c0 = cyc;
        start_burst(5, 2, 3);
        push_burst(0, c0, 2, 3, 7);
        push_idle(0, c0 + 8, 1'b0, 2);
        push_idle(0, c0 + 9, 1'b0, 2);
        tick();
        ocb.i_start = 1'b0;
        repeat (6) tick();
        ocb.i_stop = 1'b1;
        tick();
        ocb.i_stop = 1'b0;
        drain();

        // Start and stop together in IDLE: start is ignored.
        c0 = cyc;
        start_burst(2, 1, 1);
        ocb.i_stop = 1'b1;
        push_idle(0, c0 + 1, 1'b0, 2);
        push_idle(0, c0 + 2, 1'b0, 2);
        tick();
        ocb.i_start = 1'b0;
        ocb.i_stop  = 1'b0;
        drain();

        // Asynchronous reset mid-burst while the pin is high.
        c0 = cyc;
        start_burst(3, 4, 4);
        push_burst(0, c0, 4, 4, 1);
        tick();
        ocb.i_start = 1'b0;
        tick();
        chk("pre_reset_pin", 32'(ocb.o_cmp_pin), 32'd1);
        #2 i_sysrst_n = 1'b0;
        #1;
        chk("async_reset_pin",  32'(ocb.o_cmp_pin),  32'd0);
        chk("async_reset_busy", 32'(ocb.o_busy),     32'd0);
        chk("async_reset_cnt",  32'(ocb.o_cnt_data), 32'd0);
        chk("async_reset_all",  32'(observe(0)),     32'd0);
        tick();
        i_sysrst_n = 1'b1;
        tick();

        // Free-run wrap on the 8-bit instance: 257 pulses of H=1 L=1 -> count wraps to 1.
        c0 = cyc;
        ocb2.i_num = 8'd0; ocb2.i_high = 8'd1; ocb2.i_low = 8'd1; ocb2.i_start = 1'b1;
        push_burst(1, c0, 1, 1, 514);
        push_idle(1, c0 + 515, 1'b0, 1);
        push_idle(1, c0 + 516, 1'b0, 1);
        tick();
        ocb2.i_start = 1'b0;
        repeat (513) tick();
        ocb2.i_stop = 1'b1;
        tick();
        ocb2.i_stop = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
